// File: rtl/cmd_pkt_asmblr_if.sv
// Byte-in / packet-out handshake bundle for cmd_pkt_asmblr.
// slave = assembler side, master = UART/cmd_cfg side.
interface cmd_pkt_asmblr_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        timeout_err;
  logic        chk_err;

  modport master (
    output rx_rdy,
    output rx_data,
    output clr_cmd_rdy,
    input  clr_rx_rdy,
    input  cmd_rdy,
    input  cmd,
    input  data,
    input  timeout_err,
    input  chk_err
  );

  modport slave (
    input  rx_rdy,
    input  rx_data,
    input  clr_cmd_rdy,
    output clr_rx_rdy,
    output cmd_rdy,
    output cmd,
    output data,
    output timeout_err,
    output chk_err
  );
endinterface

// File: rtl/cmd_pkt_asmblr.sv
// UART byte to {cmd, data} packet assembler with inter-byte timeout.
// Define CMD_CHKSUM_EN for a 4th checksum byte ~(cmd+hi+lo).
module cmd_pkt_asmblr #(
  parameter int TIMEOUT_CLKS = 200000,
  parameter int CNT_W        = 18
) (
  input logic             clk,
  input logic             rst,
  cmd_pkt_asmblr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    CHK
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CLKS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cmd_sh;
  logic [7:0]       hi;
  logic             accept;
  logic             tmo;

  assign accept = bus.rx_rdy & ~bus.clr_rx_rdy;
  assign tmo    = (cnt == TMO_LAST);

`ifdef CMD_CHKSUM_EN
  logic [7:0] lo;
  logic [7:0] sum_n;
  assign sum_n = ~(cmd_sh + hi + lo);
`else
  assign bus.chk_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      cmd_sh          <= '0;
      hi              <= '0;
      bus.clr_rx_rdy  <= 1'b0;
      bus.cmd_rdy     <= 1'b0;
      bus.cmd         <= '0;
      bus.data        <= '0;
      bus.timeout_err <= 1'b0;
`ifdef CMD_CHKSUM_EN
      lo              <= '0;
      bus.chk_err     <= 1'b0;
`endif
    end else begin
      bus.clr_rx_rdy  <= accept;
      bus.timeout_err <= 1'b0;
`ifdef CMD_CHKSUM_EN
      bus.chk_err     <= 1'b0;
`endif
      if (bus.clr_cmd_rdy)
        bus.cmd_rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            cmd_sh      <= bus.rx_data;
            bus.cmd_rdy <= 1'b0;
            state       <= HIGH;
          end
        end
        HIGH: begin
          if (accept) begin
            hi    <= bus.rx_data;
            state <= LOW;
          end
        end
        LOW: begin
          if (accept) begin
`ifdef CMD_CHKSUM_EN
            lo    <= bus.rx_data;
            state <= CHK;
`else
            bus.cmd     <= cmd_sh;
            bus.data    <= {hi, bus.rx_data};
            bus.cmd_rdy <= 1'b1;
            state       <= IDLE;
`endif
          end
        end
`ifdef CMD_CHKSUM_EN
        CHK: begin
          if (accept) begin
            state <= IDLE;
            if (bus.rx_data == sum_n) begin
              bus.cmd     <= cmd_sh;
              bus.data    <= {hi, lo};
              bus.cmd_rdy <= 1'b1;
            end else begin
              bus.chk_err <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase

      // Counter only runs while a packet is partially received.
      if (state == IDLE || accept) begin
        cnt <= '0;
      end else if (tmo) begin
        cnt             <= '0;
        state           <= IDLE;
        bus.timeout_err <= 1'b1;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_pkt_asmblr.sv
// Directed bench for cmd_pkt_asmblr with a queue-based packet model.
// Compile with CMD_CHKSUM_EN defined to cover the checksum frame.
module tb_cmd_pkt_asmblr;

  localparam int T = 16;
`ifdef CMD_CHKSUM_EN
  localparam int FRAME = 4;
`else
  localparam int FRAME = 3;
`endif

  logic clk;
  logic rst;
  cmd_pkt_asmblr_if bus ();

  cmd_pkt_asmblr #(
    .TIMEOUT_CLKS(T),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the current frame in a queue.
  logic [7:0]  m_q[$];
  int          m_wait;
  logic        m_acc, m_done, m_first;
  logic        e_rdy, e_clr, e_tmo, e_chk;
  logic [7:0]  e_cmd;
  logic [15:0] e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_wait = 0;
      e_rdy  = 1'b0;
      e_clr  = 1'b0;
      e_tmo  = 1'b0;
      e_chk  = 1'b0;
      e_cmd  = 8'h00;
      e_data = 16'h0000;
    end else begin
      m_acc   = bus.rx_rdy && !e_clr;
      m_done  = 1'b0;
      m_first = 1'b0;
      e_tmo   = 1'b0;
      e_chk   = 1'b0;
      if (m_acc) begin
        m_first = (m_q.size() == 0);
        m_q.push_back(bus.rx_data);
        m_wait = 0;
        if (m_q.size() == FRAME) begin
`ifdef CMD_CHKSUM_EN
          m_done = (m_q[3] == 8'(~(m_q[0] + m_q[1] + m_q[2])));
          e_chk  = !m_done;
`else
          m_done = 1'b1;
`endif
          if (m_done) begin
            e_cmd  = m_q[0];
            e_data = {m_q[1], m_q[2]};
          end
          m_q.delete();
        end
      end else if (m_q.size() != 0) begin
        if (m_wait == T - 1) begin
          e_tmo = 1'b1;
          m_q.delete();
          m_wait = 0;
        end else begin
          m_wait++;
        end
      end
      if (m_done) e_rdy = 1'b1;
      else if (bus.clr_cmd_rdy) e_rdy = 1'b0;
      else if (m_first) e_rdy = 1'b0;
      e_clr = m_acc;
    end
  end

  int clr_cnt = 0;
  int tmo_cnt = 0;
  int chk_cnt = 0;

  always @(negedge clk) begin
    chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(e_clr));
    chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(e_rdy));
    chk("cmd", 32'(bus.cmd), 32'(e_cmd));
    chk("data", 32'(bus.data), 32'(e_data));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
    chk("chk_err", 32'(bus.chk_err), 32'(e_chk));
    if (bus.clr_rx_rdy) clr_cnt++;
    if (bus.timeout_err) tmo_cnt++;
    if (bus.chk_err) chk_cnt++;
  end

  task automatic send_byte(logic [7:0] b, logic clr);
    bit got;
    got = 1'b0;
    bus.rx_rdy      = 1'b1;
    bus.rx_data     = b;
    bus.clr_cmd_rdy = clr;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus.clr_cmd_rdy = 1'b0;
      if (bus.clr_rx_rdy) begin
        got = 1'b1;
        break;
      end
    end
    bus.rx_rdy = 1'b0;
    if (!got) begin
      failures++;
      $display("FAIL byte_ack: byte %0h never acknowledged", b);
    end
  endtask

  task automatic send_pkt(logic [7:0] c, logic [7:0] h, logic [7:0] l);
    send_byte(c, 1'b0);
    send_byte(h, 1'b0);
    send_byte(l, 1'b0);
`ifdef CMD_CHKSUM_EN
    send_byte(8'(~(c + h + l)), 1'b0);
`endif
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    idle(3);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    chk("rst_data", 32'(bus.data), 32'h0);
    rst = 1'b0;
    idle(2);

    // 1: basic packet, one ack per byte
    clr_cnt = 0;
    send_pkt(8'h05, 8'h01, 8'h23);
    chk("t1_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("t1_cmd", 32'(bus.cmd), 32'h05);
    chk("t1_data", 32'(bus.data), 32'h0123);
    idle(2);
    chk("t1_acks", 32'(clr_cnt), 32'(FRAME));

    // 2: consumer clears, payload held
    bus.clr_cmd_rdy = 1'b1;
    idle(1);
    bus.clr_cmd_rdy = 1'b0;
    chk("t2_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    chk("t2_cmd", 32'(bus.cmd), 32'h05);
    chk("t2_data", 32'(bus.data), 32'h0123);

    // 3: partial packet times out, next packet clean
    tmo_cnt = 0;
    send_byte(8'h02, 1'b0);
    send_byte(8'hAB, 1'b0);
    idle(T + 2);
    chk("t3_tmo", 32'(tmo_cnt), 32'h1);
    chk("t3_cmd_held", 32'(bus.cmd), 32'h05);
    send_pkt(8'h03, 8'h12, 8'h34);
    chk("t3_cmd", 32'(bus.cmd), 32'h03);
    chk("t3_data", 32'(bus.data), 32'h1234);
    idle(2);
    chk("t3_tmo_after", 32'(tmo_cnt), 32'h1);

    // 4: reset mid-packet
    send_byte(8'h04, 1'b0);
    send_byte(8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_rst_rdy", 32'(bus.cmd_rdy), 32'h0);
    chk("t4_rst_cmd", 32'(bus.cmd), 32'h00);
    chk("t4_rst_data", 32'(bus.data), 32'h0000);
    idle(2);
    rst = 1'b0;
    idle(1);
    send_pkt(8'h08, 8'h00, 8'h00);
    chk("t4_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("t4_cmd", 32'(bus.cmd), 32'h08);
    chk("t4_data", 32'(bus.data), 32'h0000);

    // 5: completion beats clr_cmd_rdy on the same edge
    send_byte(8'h0A, 1'b0);
    send_byte(8'hBC, 1'b0);
`ifdef CMD_CHKSUM_EN
    send_byte(8'hDE, 1'b0);
    send_byte(8'(~(8'h0A + 8'hBC + 8'hDE)), 1'b1);
`else
    send_byte(8'hDE, 1'b1);
`endif
    chk("t5_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("t5_cmd", 32'(bus.cmd), 32'h0A);
    chk("t5_data", 32'(bus.data), 32'hBCDE);

    // 7: byte accepted on the would-be timeout edge
    tmo_cnt = 0;
    send_byte(8'h11, 1'b0);
    idle(T - 1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
`ifdef CMD_CHKSUM_EN
    send_byte(8'(~(8'h11 + 8'h22 + 8'h33)), 1'b0);
`endif
    chk("t7_cmd", 32'(bus.cmd), 32'h11);
    chk("t7_data", 32'(bus.data), 32'h2233);
    idle(2);
    chk("t7_no_tmo", 32'(tmo_cnt), 32'h0);

`ifdef CMD_CHKSUM_EN
    // 6: checksum good and bad
    chk_cnt = 0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hB7, 1'b0);
    chk("t6_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("t6_data", 32'(bus.data), 32'h1234);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(2);
    chk("t6_chk_err", 32'(chk_cnt), 32'h1);
    chk("t6_rdy_low", 32'(bus.cmd_rdy), 32'h0);
`endif

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
